// File: rtl/core_pkg.sv
// Shared lane types for the VRF writeback network.
// Holds VRF word/strobe/address/id types, writeback bank sizing and the request bundle.
package core_pkg;

    localparam int unsigned NrWbBanks  = 4;
    localparam int unsigned WbBufDepth = 2;

    typedef enum int unsigned {
        WB_VLU  = 0,
        WB_VALU = 1
    } wb_src_e;

    typedef logic [63:0] vrf_data_t;
    typedef logic [7:0]  vrf_strb_t;
    typedef logic [7:0]  vrf_addr_t;
    typedef logic [3:0]  insn_id_t;

    typedef logic [$clog2(NrWbBanks)-1:0] wb_bank_t;

    typedef struct packed {
        vrf_data_t data;
        vrf_strb_t strb;
        vrf_addr_t addr;
        insn_id_t  id;
    } wb_req_t;

    function automatic wb_bank_t wb_bank(vrf_addr_t addr);
        return addr[$clog2(NrWbBanks)-1:0];
    endfunction

endpackage

// File: rtl/lane_wb_rr_arb.sv
// Round-robin arbiter for one VRF bank write port.
// Grants the first requester at or after the pointer; the pointer moves past the winner on adv_i.
module lane_wb_rr_arb
    import core_pkg::*;
#(
    parameter int unsigned NrSrc = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NrSrc-1:0] req_i,
    input  logic             adv_i,
    output logic [NrSrc-1:0] gnt_o
);

    localparam int unsigned PtrW = (NrSrc > 1) ? $clog2(NrSrc) : 1;
    typedef logic [PtrW-1:0] ptr_t;

    ptr_t ptr_q;
    ptr_t win;
    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < int'(NrSrc); i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= int'(NrSrc)) begin
                idx = idx - int'(NrSrc);
            end
            if (!found && req_i[ptr_t'(idx)]) begin
                found              = 1'b1;
                win                = ptr_t'(idx);
                gnt_o[ptr_t'(idx)] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (adv_i && found) begin
            ptr_q <= (win == ptr_t'(NrSrc - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/lane_wb_arbiter.sv
// Lane writeback network: per-source result FIFOs routed to banked VRF write ports.
// Define LANE_WB_BYPASS_EN to let an empty-FIFO source write its incoming result in the same cycle.
module lane_wb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned NrSrc    = 2,
    parameter int unsigned NrBanks  = NrWbBanks,
    parameter int unsigned BufDepth = WbBufDepth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic      [NrSrc-1:0]    src_valid_i,
    output logic      [NrSrc-1:0]    src_gnt_o,
    input  vrf_data_t [NrSrc-1:0]    src_wdata_i,
    input  vrf_strb_t [NrSrc-1:0]    src_wstrb_i,
    input  vrf_addr_t [NrSrc-1:0]    src_addr_i,
    input  insn_id_t  [NrSrc-1:0]    src_id_i,
    input  logic      [NrBanks-1:0]  bank_ready_i,
    output logic      [NrBanks-1:0]  bank_we_o,
    output vrf_addr_t [NrBanks-1:0]  bank_addr_o,
    output vrf_data_t [NrBanks-1:0]  bank_wdata_o,
    output vrf_strb_t [NrBanks-1:0]  bank_wstrb_o,
    output logic      [NrSrc-1:0]    wb_done_o,
    output insn_id_t  [NrSrc-1:0]    wb_done_id_o
);

    localparam int unsigned LogBanks = $clog2(NrBanks);
    localparam int unsigned BankW    = (NrBanks > 1) ? LogBanks : 1;
    localparam int unsigned PtrW     = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int unsigned CntW     = $clog2(BufDepth + 1);

    typedef logic [PtrW-1:0]  ptr_t;
    typedef logic [CntW-1:0]  cnt_t;
    typedef logic [BankW-1:0] bank_t;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(BufDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    wb_req_t [BufDepth-1:0] mem_q [NrSrc];
    ptr_t                   rd_q  [NrSrc];
    ptr_t                   wr_q  [NrSrc];
    cnt_t                   cnt_q [NrSrc];

    logic    [NrSrc-1:0] full;
    logic    [NrSrc-1:0] empty;
    logic    [NrSrc-1:0] byp;
    logic    [NrSrc-1:0] req_v;
    logic    [NrSrc-1:0] served;
    logic    [NrSrc-1:0] push;
    logic    [NrSrc-1:0] pop;
    wb_req_t [NrSrc-1:0] in_req;
    wb_req_t [NrSrc-1:0] req;
    bank_t   [NrSrc-1:0] req_bank;

    logic [NrBanks-1:0][NrSrc-1:0] bank_req;
    logic [NrBanks-1:0][NrSrc-1:0] bank_gnt;

    // A source presents its FIFO head, or the live input when bypassing.
    always_comb begin
        full     = '0;
        empty    = '0;
        byp      = '0;
        req_v    = '0;
        in_req   = '0;
        req      = '0;
        req_bank = '0;
        for (int s = 0; s < int'(NrSrc); s++) begin
            in_req[s] = '{data: src_wdata_i[s], strb: src_wstrb_i[s],
                          addr: src_addr_i[s], id: src_id_i[s]};
            full[s]   = (cnt_q[s] == cnt_t'(BufDepth));
            empty[s]  = (cnt_q[s] == '0);
`ifdef LANE_WB_BYPASS_EN
            byp[s]    = empty[s] & src_valid_i[s];
`else
            byp[s]    = 1'b0;
`endif
            req[s]      = empty[s] ? in_req[s] : mem_q[s][rd_q[s]];
            req_v[s]    = !empty[s] | byp[s];
            req_bank[s] = bank_t'(req[s].addr & vrf_addr_t'(NrBanks - 1));
        end
    end

    always_comb begin
        bank_req = '0;
        for (int b = 0; b < int'(NrBanks); b++) begin
            for (int s = 0; s < int'(NrSrc); s++) begin
                bank_req[b][s] = req_v[s] && (req_bank[s] == bank_t'(b));
            end
        end
    end

    for (genvar b = 0; b < int'(NrBanks); b++) begin : g_bank
        lane_wb_rr_arb #(
            .NrSrc (NrSrc)
        ) i_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req_i  (bank_req[b]),
            .adv_i  (bank_ready_i[b]),
            .gnt_o  (bank_gnt[b])
        );
    end

    always_comb begin
        bank_we_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_wstrb_o = '0;
        served       = '0;
        for (int b = 0; b < int'(NrBanks); b++) begin
            bank_we_o[b] = bank_ready_i[b] & (|bank_req[b]);
            for (int s = 0; s < int'(NrSrc); s++) begin
                if (bank_we_o[b] && bank_gnt[b][s]) begin
                    served[s]       = 1'b1;
                    bank_addr_o[b]  = req[s].addr >> LogBanks;
                    bank_wdata_o[b] = req[s].data;
                    bank_wstrb_o[b] = req[s].strb;
                end
            end
        end
    end

    // A bypassed result that wins is consumed directly and never stored.
    always_comb begin
        wb_done_o    = served;
        wb_done_id_o = '0;
        push         = '0;
        pop          = '0;
        for (int s = 0; s < int'(NrSrc); s++) begin
            wb_done_id_o[s] = served[s] ? req[s].id : '0;
            pop[s]  = served[s] & !empty[s];
            push[s] = src_valid_i[s] & !full[s] & !(served[s] & empty[s]);
        end
    end

    assign src_gnt_o = ~full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(NrSrc); s++) begin
                mem_q[s] <= '0;
                rd_q[s]  <= '0;
                wr_q[s]  <= '0;
                cnt_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(NrSrc); s++) begin
                if (push[s]) begin
                    mem_q[s][wr_q[s]] <= in_req[s];
                    wr_q[s]           <= ptr_inc(wr_q[s]);
                end
                if (pop[s]) begin
                    rd_q[s] <= ptr_inc(rd_q[s]);
                end
                case ({push[s], pop[s]})
                    2'b10:   cnt_q[s] <= cnt_q[s] + 1'b1;
                    2'b01:   cnt_q[s] <= cnt_q[s] - 1'b1;
                    default: cnt_q[s] <= cnt_q[s];
                endcase
            end
        end
    end

endmodule
